// File: rtl/invaders_pkg.sv
// Shared types, colours and BCD helpers for the invaders game-control core.
package invaders_pkg;

   typedef enum logic [1:0] {
      ATTRACT   = 2'd0,
      PLAY      = 2'd1,
      HIT       = 2'd2,
      GAME_OVER = 2'd3
   } game_state_t;

   localparam logic [11:0] COL_BLACK  = 12'h000;
   localparam logic [11:0] COL_LASER  = 12'hF00;
   localparam logic [11:0] COL_CANNON = 12'h0F0;
   localparam logic [11:0] COL_BOMB   = 12'hFF0;
   localparam logic [11:0] COL_ALIEN  = 12'h00F;

   // Converts a small binary value (0..63) into two packed BCD digits {tens, units}.
   function automatic logic [7:0] bin_to_bcd2(input logic [5:0] value);
      logic [3:0] tens;
      logic [3:0] units;
      tens  = 4'(value / 6'd10);
      units = 4'(value % 6'd10);
      return {tens, units};
   endfunction

   // One BCD digit add with carry; returns {carry_out, digit}.
   function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                                input logic cin);
      logic [4:0] raw;
      raw = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      if (raw > 5'd9) begin
         return {1'b1, 4'(raw - 5'd10)};
      end
      return {1'b0, raw[3:0]};
   endfunction

endpackage

// File: rtl/invaders_game_ctrl_bcd_score_counter.sv
// Multi-digit BCD score register: ripple-carry add of a two-digit BCD amount, saturating at all nines.
module bcd_score_counter
   import invaders_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  add_en,
   input  logic [7:0]            add_bcd,
   output logic [4*DIGITS-1:0]   score
);

   // The adder is at least two digits wide so the tens digit of the addend always has a home.
   localparam int W  = (DIGITS < 2) ? 2 : DIGITS;
   localparam int EW = 4 * W;

   logic [4*DIGITS-1:0] score_q;
   logic [4*DIGITS-1:0] sum;
   logic [EW-1:0]       score_ext;
   logic [EW-1:0]       add_ext;
   logic [EW-1:0]       sum_ext;
   logic [4:0]          digit_res;
   logic                carry;
   logic                overflow;

   // Any carry out of the top digit, or a nonzero digit above the score width, pins the score at 9s.
   always_comb begin
      score_ext = EW'(score_q);
      add_ext   = EW'(add_bcd);
      sum_ext   = '0;
      digit_res = '0;
      carry     = 1'b0;
      for (int d = 0; d < W; d++) begin
         digit_res            = bcd_digit_add(score_ext[4*d +: 4], add_ext[4*d +: 4], carry);
         sum_ext[4*d +: 4]    = digit_res[3:0];
         carry                = digit_res[4];
      end
      overflow = carry;
      for (int d = DIGITS; d < W; d++) begin
         overflow = overflow | (sum_ext[4*d +: 4] != 4'd0);
      end
      sum = overflow ? {DIGITS{4'h9}} : sum_ext[4*DIGITS-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_q <= '0;
      end else if (clear) begin
         score_q <= '0;
      end else if (add_en) begin
         score_q <= sum;
      end
   end

   assign score = score_q;

endmodule

// File: rtl/invaders_game_ctrl.sv
// Invaders game-control core: frame-latched collisions, score/lives/wave keeping,
// game state machine and registered RGB compositor on the pixel clock.
module invaders_game_ctrl
   import invaders_pkg::*;
#(
   parameter int NUM_LASERS     = 1,
   parameter int SCORE_DIGITS   = 4,
   parameter int POINTS_PER_HIT = 1,
   parameter int START_LIVES    = 3,
   parameter int HIT_FRAMES     = 60,
   parameter int OVER_FRAMES    = 120,
   parameter bit VS_ACTIVE_HIGH = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      hsync,
   input  logic                      vsync,
   input  logic                      display_on,
   input  logic                      start,
   input  logic [NUM_LASERS-1:0]     laser_gfx,
   input  logic                      alien_gfx,
   input  logic                      cannon_gfx,
   input  logic                      bomb_gfx,
   input  logic [5:0]                aliens_left,
   output logic [NUM_LASERS-1:0]     hit_alien,
   output logic                      cannon_hit,
   output logic [1:0]                game_state,
   output logic [4*SCORE_DIGITS-1:0] score_bcd,
   output logic [2:0]                lives,
   output logic [3:0]                wave,
   output logic                      frame_tick,
   output logic [3:0]                vga_r,
   output logic [3:0]                vga_g,
   output logic [3:0]                vga_b,
   output logic                      vga_hs,
   output logic                      vga_vs
);

   localparam int FRAME_MAX = (HIT_FRAMES > OVER_FRAMES) ? HIT_FRAMES : OVER_FRAMES;
   localparam int FC_RAW    = $clog2(FRAME_MAX + 1);
   localparam int FC_W      = (FC_RAW < 4) ? 4 : FC_RAW;

   game_state_t           state;
   game_state_t           next_state;
   logic [2:0]            next_lives;
   logic [3:0]            next_wave;
   logic [FC_W-1:0]       frame_cnt;
   logic [FC_W-1:0]       next_frame_cnt;
   logic                  score_clear;
   logic                  life_lost;
   logic                  vs_active;
   logic                  vs_q;
   logic                  start_q;
   logic                  start_rise;
   logic [NUM_LASERS-1:0] laser_set;
   logic [NUM_LASERS-1:0] laser_flag;
   logic                  cannon_set;
   logic                  cannon_flag;
   logic [2:0]            hit_count;
   logic [5:0]            points;
   logic                  score_add_en;
   logic                  cannon_visible;
   logic [11:0]           pixel_colour;

   assign vs_active  = VS_ACTIVE_HIGH ? vsync : ~vsync;
   assign start_rise = start & ~start_q;
   assign laser_set  = laser_gfx & {NUM_LASERS{display_on & alien_gfx}};
   assign cannon_set = display_on & bomb_gfx & cannon_gfx;

   always_comb begin
      hit_count = '0;
      for (int i = 0; i < NUM_LASERS; i++) begin
         hit_count = hit_count + {2'b00, laser_flag[i]};
      end
   end

   assign points       = 6'(POINTS_PER_HIT) * {3'b000, hit_count};
   assign score_add_en = frame_tick & ((state == PLAY) | (state == HIT));

   bcd_score_counter #(
      .DIGITS (SCORE_DIGITS)
   ) u_score (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (score_clear),
      .add_en  (score_add_en),
      .add_bcd (bin_to_bcd2(points)),
      .score   (score_bcd)
   );

   // A collision on the tick cycle itself belongs to the frame that is just starting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q        <= 1'b1;
         frame_tick  <= 1'b0;
         start_q     <= 1'b0;
         laser_flag  <= '0;
         cannon_flag <= 1'b0;
         hit_alien   <= '0;
      end else begin
         vs_q       <= vs_active;
         frame_tick <= vs_active & ~vs_q;
         start_q    <= start;
         if (frame_tick) begin
            hit_alien   <= laser_flag;
            laser_flag  <= laser_set;
            cannon_flag <= cannon_set;
         end else begin
            laser_flag  <= laser_flag | laser_set;
            cannon_flag <= cannon_flag | cannon_set;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ATTRACT;
         lives      <= 3'd0;
         wave       <= 4'd0;
         frame_cnt  <= '0;
         cannon_hit <= 1'b0;
      end else begin
         state      <= next_state;
         lives      <= next_lives;
         wave       <= next_wave;
         frame_cnt  <= next_frame_cnt;
         cannon_hit <= life_lost;
      end
   end

   // Only start acts off-tick; a cannon hit and a cleared wave on the same tick both take effect.
   always_comb begin
      next_state     = state;
      next_lives     = lives;
      next_wave      = wave;
      next_frame_cnt = frame_cnt;
      score_clear    = 1'b0;
      life_lost      = 1'b0;
      case (state)
         ATTRACT: begin
            if (start_rise) begin
               next_state  = PLAY;
               next_lives  = 3'(START_LIVES);
               next_wave   = 4'd1;
               score_clear = 1'b1;
            end
         end
         PLAY: begin
            if (frame_tick) begin
               if ((aliens_left == 6'd0) && (wave != 4'd15)) begin
                  next_wave = wave + 4'd1;
               end
               if (cannon_flag) begin
                  next_state     = HIT;
                  next_lives     = (lives != 3'd0) ? lives - 3'd1 : 3'd0;
                  next_frame_cnt = '0;
                  life_lost      = 1'b1;
               end
            end
         end
         HIT: begin
            if (frame_tick) begin
               if (frame_cnt == FC_W'(HIT_FRAMES - 1)) begin
                  next_state     = (lives == 3'd0) ? GAME_OVER : PLAY;
                  next_frame_cnt = '0;
               end else begin
                  next_frame_cnt = frame_cnt + 1'b1;
               end
            end
         end
         GAME_OVER: begin
            if (frame_tick) begin
               if (frame_cnt == FC_W'(OVER_FRAMES - 1)) begin
                  next_state     = ATTRACT;
                  next_frame_cnt = '0;
               end else begin
                  next_frame_cnt = frame_cnt + 1'b1;
               end
            end
         end
         default: next_state = ATTRACT;
      endcase
   end

   assign game_state = state;

   // The cannon blinks while invulnerable: hidden whenever bit 3 of the frame counter is set.
   assign cannon_visible = cannon_gfx &
                           ((state == PLAY) | ((state == HIT) & ~frame_cnt[3]));

   always_comb begin
      pixel_colour = COL_BLACK;
      if (display_on) begin
         if (|laser_gfx) begin
            pixel_colour = COL_LASER;
         end else if (cannon_visible) begin
            pixel_colour = COL_CANNON;
         end else if (bomb_gfx) begin
            pixel_colour = COL_BOMB;
         end else if (alien_gfx) begin
            pixel_colour = COL_ALIEN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_r  <= 4'd0;
         vga_g  <= 4'd0;
         vga_b  <= 4'd0;
         vga_hs <= 1'b0;
         vga_vs <= 1'b0;
      end else begin
         {vga_r, vga_g, vga_b} <= pixel_colour;
         vga_hs                <= hsync;
         vga_vs                <= vsync;
      end
   end

endmodule

// File: tb/tb_invaders_game_ctrl.sv
// Directed bench: a default-parameter core plus a two-laser, five-point core for score saturation.
module tb_invaders_game_ctrl;
   import invaders_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hsync = 1'b1;
   logic        vsync = 1'b1;
   logic        display_on = 1'b0;
   logic        start = 1'b0;
   logic        start2 = 1'b0;
   logic [0:0]  laser_gfx = 1'b0;
   logic [1:0]  laser2 = 2'b00;
   logic        alien_gfx = 1'b0;
   logic        cannon_gfx = 1'b0;
   logic        bomb_gfx = 1'b0;
   logic [5:0]  aliens_left = 6'd10;

   logic [0:0]  hit_alien;
   logic        cannon_hit;
   logic [1:0]  game_state;
   logic [15:0] score_bcd;
   logic [2:0]  lives;
   logic [3:0]  wave;
   logic        frame_tick;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs;

   logic [1:0]  hit2;
   logic        cannon_hit2;
   logic [1:0]  state2;
   logic [15:0] score2;
   logic [2:0]  lives2;
   logic [3:0]  wave2;
   logic        tick2;
   logic [3:0]  r2, g2, b2;
   logic        hs2, vs2;

   logic [11:0] rgb;
   int          checks = 0;
   int          passed = 0;
   int          tick_pulses;
   int          ch_pulses;

   assign rgb = {vga_r, vga_g, vga_b};

   always #5 clk = ~clk;

   invaders_game_ctrl dut (
      .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .display_on(display_on),
      .start(start), .laser_gfx(laser_gfx), .alien_gfx(alien_gfx), .cannon_gfx(cannon_gfx),
      .bomb_gfx(bomb_gfx), .aliens_left(aliens_left), .hit_alien(hit_alien),
      .cannon_hit(cannon_hit), .game_state(game_state), .score_bcd(score_bcd), .lives(lives),
      .wave(wave), .frame_tick(frame_tick), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs)
   );

   invaders_game_ctrl #(.NUM_LASERS(2), .POINTS_PER_HIT(5)) dut2 (
      .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .display_on(display_on),
      .start(start2), .laser_gfx(laser2), .alien_gfx(alien_gfx), .cannon_gfx(cannon_gfx),
      .bomb_gfx(bomb_gfx), .aliens_left(aliens_left), .hit_alien(hit2),
      .cannon_hit(cannon_hit2), .game_state(state2), .score_bcd(score2), .lives(lives2),
      .wave(wave2), .frame_tick(tick2), .vga_r(r2), .vga_g(g2), .vga_b(b2),
      .vga_hs(hs2), .vga_vs(vs2)
   );

   // One visible pixel cycle; returns at the next falling edge where its RGB is registered.
   task automatic pixel(input logic [1:0] l2, input logic l, input logic a, input logic c,
                        input logic b, input logic hs);
      display_on = 1'b1;
      vsync      = 1'b1;
      laser2     = l2;
      laser_gfx  = l;
      alien_gfx  = a;
      cannon_gfx = c;
      bomb_gfx   = b;
      hsync      = hs;
      @(negedge clk);
   endtask

   // Frame boundary: vsync active for two cycles, counting frame_tick and cannon_hit pulses.
   task automatic vsync_pulse();
      display_on  = 1'b0;
      laser_gfx   = 1'b0;
      laser2      = 2'b00;
      alien_gfx   = 1'b0;
      cannon_gfx  = 1'b0;
      bomb_gfx    = 1'b0;
      hsync       = 1'b1;
      vsync       = 1'b0;
      tick_pulses = 0;
      ch_pulses   = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k == 1) vsync = 1'b1;
         tick_pulses += int'(frame_tick);
         ch_pulses   += int'(cannon_hit);
      end
   endtask

   task automatic run_frames(input int n);
      for (int f = 0; f < n; f++) vsync_pulse();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      pixel(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      pixel(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      checks++; if (game_state !== ATTRACT) $display("FAIL reset_state got %0d want %0d", game_state, ATTRACT); else passed++;
      checks++; if ({score_bcd, lives, wave} !== 23'd0) $display("FAIL reset_counters got %h/%0d/%0d want 0/0/0", score_bcd, lives, wave); else passed++;
      checks++; if ({hit_alien, cannon_hit, frame_tick} !== 3'b000) $display("FAIL reset_pulses got %b want 000", {hit_alien, cannon_hit, frame_tick}); else passed++;
      checks++; if ({rgb, vga_hs, vga_vs} !== 14'd0) $display("FAIL reset_vga got %h/%b/%b want 000/0/0", rgb, vga_hs, vga_vs); else passed++;
      display_on = 1'b0; laser_gfx = 1'b0; laser2 = 2'b00; alien_gfx = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      vsync_pulse();
      checks++; if (tick_pulses !== 1) $display("FAIL frame_tick_count got %0d want 1", tick_pulses); else passed++;
      checks++; if ({hit_alien, hit2} !== 3'b000) $display("FAIL post_reset_hits got %b want 000", {hit_alien, hit2}); else passed++;
      checks++; if ({game_state, score_bcd, rgb} !== 30'd0) $display("FAIL post_reset_idle got %0d/%h/%h want 0/0000/000", game_state, score_bcd, rgb); else passed++;
   endtask

   task automatic test_start_laser();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (game_state !== PLAY) $display("FAIL start_state got %0d want %0d", game_state, PLAY); else passed++;
      checks++; if ({lives, wave, score_bcd} !== {3'd3, 4'd1, 16'h0000}) $display("FAIL start_load got %0d/%0d/%h want 3/1/0000", lives, wave, score_bcd); else passed++;
      for (int p = 0; p < 3; p++) pixel(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      pixel(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      pixel(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      vsync_pulse();
      checks++; if (hit_alien !== 1'b1) $display("FAIL laser_hit got %b want 1", hit_alien); else passed++;
      checks++; if (score_bcd !== 16'h0001) $display("FAIL laser_score got %h want 0001", score_bcd); else passed++;
      display_on = 1'b0; laser_gfx = 1'b1; alien_gfx = 1'b1;
      @(negedge clk);
      vsync_pulse();
      checks++; if (hit_alien !== 1'b0) $display("FAIL hit_cleared got %b want 0", hit_alien); else passed++;
      checks++; if (score_bcd !== 16'h0001) $display("FAIL score_held got %h want 0001", score_bcd); else passed++;
   endtask

   task automatic test_wave();
      aliens_left = 6'd0;
      vsync_pulse();
      aliens_left = 6'd10;
      checks++; if (wave !== 4'd2) $display("FAIL wave_inc got %0d want 2", wave); else passed++;
      vsync_pulse();
      checks++; if (wave !== 4'd2) $display("FAIL wave_hold got %0d want 2", wave); else passed++;
   endtask

   task automatic test_compositor();
      pixel(2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if ({rgb, vga_hs, vga_vs} !== {12'hF00, 1'b0, 1'b1}) $display("FAIL comp_laser got %h/%b/%b want F00/0/1", rgb, vga_hs, vga_vs); else passed++;
      pixel(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      checks++; if ({rgb, vga_hs} !== {12'h0F0, 1'b1}) $display("FAIL comp_cannon got %h/%b want 0F0/1", rgb, vga_hs); else passed++;
      pixel(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      checks++; if ({rgb, vga_hs} !== {12'hFF0, 1'b0}) $display("FAIL comp_bomb got %h/%b want FF0/0", rgb, vga_hs); else passed++;
      pixel(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++; if (rgb !== 12'h00F) $display("FAIL comp_alien got %h want 00F", rgb); else passed++;
      pixel(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++; if (rgb !== 12'hF00) $display("FAIL comp_laser_bomb got %h want F00", rgb); else passed++;
      display_on = 1'b0;
      @(negedge clk);
      checks++; if (rgb !== 12'h000) $display("FAIL comp_blank got %h want 000", rgb); else passed++;
      vsync_pulse();
      checks++; if (score_bcd !== 16'h0002) $display("FAIL comp_score got %h want 0002", score_bcd); else passed++;
   endtask

   task automatic test_cannon_hit();
      pixel(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      vsync_pulse();
      checks++; if ({ch_pulses, lives, game_state} !== {32'd1, 3'd2, HIT}) $display("FAIL hit1 got %0d/%0d/%0d want 1/2/2", ch_pulses, lives, game_state); else passed++;
      pixel(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++; if (rgb !== 12'h0F0) $display("FAIL blink_on0 got %h want 0F0", rgb); else passed++;
      pixel(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      vsync_pulse();
      checks++; if ({ch_pulses, lives} !== {32'd0, 3'd2}) $display("FAIL hit_in_hit got %0d/%0d want 0/2", ch_pulses, lives); else passed++;
      run_frames(7);
      pixel(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++; if (rgb !== 12'h000) $display("FAIL blink_off8 got %h want 000", rgb); else passed++;
      run_frames(8);
      pixel(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++; if (rgb !== 12'h0F0) $display("FAIL blink_on16 got %h want 0F0", rgb); else passed++;
      run_frames(43);
      checks++; if (game_state !== HIT) $display("FAIL hit_frame59 got %0d want %0d", game_state, HIT); else passed++;
      run_frames(1);
      checks++; if ({game_state, lives} !== {PLAY, 3'd2}) $display("FAIL hit_to_play got %0d/%0d want 1/2", game_state, lives); else passed++;
      pixel(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      vsync_pulse();
      checks++; if ({ch_pulses, lives} !== {32'd1, 3'd1}) $display("FAIL hit2 got %0d/%0d want 1/1", ch_pulses, lives); else passed++;
      run_frames(60);
      aliens_left = 6'd0;
      pixel(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      vsync_pulse();
      aliens_left = 6'd10;
      checks++; if ({ch_pulses, lives, wave, game_state} !== {32'd1, 3'd0, 4'd3, HIT}) $display("FAIL hit_and_wave got %0d/%0d/%0d/%0d want 1/0/3/2", ch_pulses, lives, wave, game_state); else passed++;
      run_frames(59);
      checks++; if (game_state !== HIT) $display("FAIL last_hit_frame got %0d want %0d", game_state, HIT); else passed++;
      run_frames(1);
      checks++; if (game_state !== GAME_OVER) $display("FAIL game_over got %0d want %0d", game_state, GAME_OVER); else passed++;
      pixel(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++; if (rgb !== 12'h000) $display("FAIL over_cannon_hidden got %h want 000", rgb); else passed++;
      run_frames(119);
      checks++; if ({game_state, score_bcd} !== {GAME_OVER, 16'h0002}) $display("FAIL over_hold got %0d/%h want 3/0002", game_state, score_bcd); else passed++;
      start = 1'b1;
      run_frames(1);
      checks++; if (game_state !== ATTRACT) $display("FAIL to_attract got %0d want %0d", game_state, ATTRACT); else passed++;
      run_frames(2);
      checks++; if ({game_state, score_bcd} !== {ATTRACT, 16'h0002}) $display("FAIL held_start got %0d/%h want 0/0002", game_state, score_bcd); else passed++;
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if ({game_state, lives, wave, score_bcd} !== {PLAY, 3'd3, 4'd1, 16'h0000}) $display("FAIL restart got %0d/%0d/%0d/%h want 1/3/1/0000", game_state, lives, wave, score_bcd); else passed++;
   endtask

   task automatic test_wave_saturate();
      aliens_left = 6'd0;
      run_frames(16);
      aliens_left = 6'd10;
      checks++; if (wave !== 4'd15) $display("FAIL wave_sat got %0d want 15", wave); else passed++;
   endtask

   task automatic test_score_saturate();
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      checks++; if (state2 !== PLAY) $display("FAIL dut2_start got %0d want %0d", state2, PLAY); else passed++;
      pixel(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      vsync_pulse();
      checks++; if ({hit2, score2} !== {2'b11, 16'h0010}) $display("FAIL two_lasers got %b/%h want 11/0010", hit2, score2); else passed++;
      pixel(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      pixel(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      vsync_pulse();
      checks++; if ({hit2, score2} !== {2'b01, 16'h0015}) $display("FAIL one_laser got %b/%h want 01/0015", hit2, score2); else passed++;
      for (int f = 0; f < 998; f++) begin
         pixel(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
         vsync_pulse();
      end
      checks++; if (score2 !== 16'h9995) $display("FAIL score_9995 got %h want 9995", score2); else passed++;
      pixel(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      vsync_pulse();
      checks++; if (score2 !== 16'h9999) $display("FAIL score_sat got %h want 9999", score2); else passed++;
      pixel(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      vsync_pulse();
      checks++; if (score2 !== 16'h9999) $display("FAIL score_sat_hold got %h want 9999", score2); else passed++;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached after %0d checks", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_start_laser();
      test_wave();
      test_compositor();
      test_cannon_hit();
      test_wave_saturate();
      test_score_saturate();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
